mcpu_alu_sequencer: RTL
=======================

# mcpu_alu_sequencer

Multicycle controller that drives the micro-CPU's `MCPU_Alu` from the initiating side. It fetches 16-bit instructions from an external synchronous instruction memory and reads operands from an internal 4×WORD_SIZE register file. It issues opcode and operands to the combinational ALU, then writes the result and the overflow flag back. It replaces bench-driven ALU stimulus with program-driven stimulus and sits between instruction memory and the ALU in the CPU datapath.

## Interface
- `CMD_SIZE`, 2, ALU command width
- `WORD_SIZE`, 8, data, register and PC width
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALTED
- `instr_addr`  output  WORD_SIZE  instruction memory address
- `instr_rd`  output  1  instruction read strobe
- `instr_data`  input  2*WORD_SIZE  instruction; valid one cycle after `instr_rd`
- `alu_opcode`  output  CMD_SIZE  ALU command
- `alu_r1`, `alu_r2`  output  WORD_SIZE  ALU operands
- `alu_out`  input  WORD_SIZE  ALU result (combinational)
- `alu_overflow`  input  1  ALU overflow (combinational)
- `ovf_flag`  output  1  overflow of last ALU-class instruction
- `busy`  output  1  high in FETCH/DECODE/EXECUTE
- `halted`  output  1  high in HALTED
- `dbg_sel`  input  2  register select for debug read
- `dbg_data`  output  WORD_SIZE  combinational read of register `dbg_sel`

## Operation
- Instruction fields:
  - [15:14] class: 00 ALU, 01 LDI, 10 JMP, 11 HALT
  - [13:12] cmd: AND=0, OR=1, XOR=2, ADD=3
  - [11:10] rd
  - [9:8] rs1
  - [7:6] rs2
  - [7:0] imm/target
  - Unused bits are ignored.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, HALTED.
  - IDLE → FETCH on `start`; `pc` is set to 0.
  - FETCH → DECODE. `instr_rd`=1 and `instr_addr`=`pc`.
  - DECODE → EXECUTE. IR latches `instr_data`.
  - EXECUTE → FETCH for ALU, LDI and JMP; → HALTED for HALT.
  - HALTED → FETCH on `start`; `pc` is set to 0.
- EXECUTE by class:
  - ALU: drives `alu_opcode`=cmd, `alu_r1`=reg[rs1], `alu_r2`=reg[rs2]. Writes reg[rd]=`alu_out` and `ovf_flag`=`alu_overflow`. `pc`=`pc`+1.
  - LDI: reg[rd]=imm; `pc`=`pc`+1; `ovf_flag` unchanged.
  - JMP: `pc`=target; registers and `ovf_flag` unchanged.
  - HALT: `pc` is held.
- `pc` increments modulo 2^WORD_SIZE, so 0xFF wraps to 0x00.
- rd may equal rs1 or rs2. Operands are read before the write, and the new value is visible from the next instruction onward.
- `alu_opcode`, `alu_r1` and `alu_r2` are 0 outside EXECUTE of the ALU class.
- `start` is ignored while `busy`=1.
- Reset values:
  - State is IDLE.
  - `pc`, IR, all registers and `ovf_flag` are 0.
  - `instr_rd`, `busy` and `halted` are 0.
  - `instr_addr` is 0 and the ALU outputs are 0.

## Timing
- `start` sampled high at edge N:
  - FETCH occupies cycle N+1.
  - DECODE occupies N+2, with `instr_data` sampled at the end of N+2.
  - EXECUTE occupies N+3, with the register/`ovf_flag` write at the end of N+3.
  - The result is visible on `dbg_data` from N+4.
- Every instruction takes 3 cycles. The next FETCH starts the cycle after EXECUTE.
- `halted` rises the cycle after EXECUTE of HALT. After restart, the next FETCH follows `start` by 1 cycle.
- Reset in any state, including mid-EXECUTE, takes effect immediately. No write completes, and all outputs return to their reset values asynchronously.

## Structure
- Package `mcpu_pkg` holds:
  - the CMD_AND/OR/XOR/ADD constants
  - the instruction class constants
  - the field bit positions
  - the FSM state enum
  - the CMD_SIZE/WORD_SIZE defaults
- Sub-module `mcpu_regfile`:
  - 4×WORD_SIZE registers
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - asynchronous active-high reset to 0
- `MCPU_Alu` is instantiated outside this block, at the CPU top level.

## Test plan
- LDI r1,2; LDI r2,6; ALU ADD r3,r1,r2; HALT → r3=8, `ovf_flag`=0, `halted`=1. `instr_addr` sequence 0,1,2,3.
- LDI r0,200; LDI r1,100; ADD r2,r0,r1 → r2=44, `ovf_flag`=1. A following AND r3,r0,r1 → r3=0x40, `ovf_flag`=0.
- XOR r1,r1,r1 with r1=0xA5 → r1=0. OR r2,r0,r0 with r0=6 → r2=6.
- JMP 0x05 at address 0 → next `instr_addr`=5. A program of LDI filling 0xFF, whose next fetch comes from 0x00, shows `pc` wrap.
- HALT, then `start` pulse → `halted` falls, FETCH at address 0 one cycle later. `start` during `busy` has no effect.
- Reset asserted in EXECUTE of ADD → destination register stays at its prior reset value 0, state is IDLE, and `instr_rd`=0 the same cycle.

Source files
------------

// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_pkg
// Brief    : Shared constants, instruction field positions and FSM states for
//            the micro-CPU ALU sequencer.
// Revision : 1.0
// ============================================================================
package mcpu_pkg;

    localparam int CMD_SIZE_DEF  = 2;
    localparam int WORD_SIZE_DEF = 8;

    localparam logic [1:0] CMD_AND = 2'd0;
    localparam logic [1:0] CMD_OR  = 2'd1;
    localparam logic [1:0] CMD_XOR = 2'd2;
    localparam logic [1:0] CMD_ADD = 2'd3;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LDI  = 2'd1;
    localparam logic [1:0] CLS_JMP  = 2'd2;
    localparam logic [1:0] CLS_HALT = 2'd3;

    localparam int F_CLS_MSB = 15;
    localparam int F_CLS_LSB = 14;
    localparam int F_CMD_MSB = 13;
    localparam int F_CMD_LSB = 12;
    localparam int F_RD_MSB  = 11;
    localparam int F_RD_LSB  = 10;
    localparam int F_RS1_MSB = 9;
    localparam int F_RS1_LSB = 8;
    localparam int F_RS2_MSB = 7;
    localparam int F_RS2_LSB = 6;
    localparam int F_IMM_MSB = 7;
    localparam int F_IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mcpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_regfile
// Brief    : 4-entry register file, two operand read ports, a debug read
//            port and one synchronous write port.
// Revision : 1.0
// ============================================================================
module mcpu_regfile
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [1:0]           waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [1:0]           raddr1,
    input  logic [1:0]           raddr2,
    input  logic [1:0]           dbg_sel,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [WORD_SIZE-1:0] rdata2,
    output logic [WORD_SIZE-1:0] dbg_data
);

    logic [WORD_SIZE-1:0] r_regs [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1   = r_regs[raddr1];
    assign rdata2   = r_regs[raddr2];
    assign dbg_data = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: rtl/mcpu_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_alu_sequencer
// Brief    : Fetch/decode/execute controller feeding a combinational ALU from
//            an instruction memory and a small register file.
// Revision : 1.0
// ============================================================================
module mcpu_alu_sequencer
    import mcpu_pkg::*;
#(
    parameter int CMD_SIZE  = CMD_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [WORD_SIZE-1:0]   instr_addr,
    output logic                   instr_rd,
    input  logic [2*WORD_SIZE-1:0] instr_data,
    output logic [CMD_SIZE-1:0]    alu_opcode,
    output logic [WORD_SIZE-1:0]   alu_r1,
    output logic [WORD_SIZE-1:0]   alu_r2,
    input  logic [WORD_SIZE-1:0]   alu_out,
    input  logic                   alu_overflow,
    output logic                   ovf_flag,
    output logic                   busy,
    output logic                   halted,
    input  logic [1:0]             dbg_sel,
    output logic [WORD_SIZE-1:0]   dbg_data
);

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_pc;
    logic [2*WORD_SIZE-1:0] r_ir;

    logic [1:0]             w_cls;
    logic [1:0]             w_cmd;
    logic [1:0]             w_rd;
    logic [1:0]             w_rs1;
    logic [1:0]             w_rs2;
    logic [WORD_SIZE-1:0]   w_imm;
    logic                   w_exec;
    logic                   w_alu_en;
    logic                   w_we;
    logic [WORD_SIZE-1:0]   w_wdata;
    logic [WORD_SIZE-1:0]   w_rdata1;
    logic [WORD_SIZE-1:0]   w_rdata2;
    logic [WORD_SIZE-1:0]   w_pc_next;

    assign w_cls = r_ir[F_CLS_MSB:F_CLS_LSB];
    assign w_cmd = r_ir[F_CMD_MSB:F_CMD_LSB];
    assign w_rd  = r_ir[F_RD_MSB:F_RD_LSB];
    assign w_rs1 = r_ir[F_RS1_MSB:F_RS1_LSB];
    assign w_rs2 = r_ir[F_RS2_MSB:F_RS2_LSB];
    assign w_imm = WORD_SIZE'(r_ir[F_IMM_MSB:F_IMM_LSB]);

    assign w_exec    = (r_state == ST_EXECUTE);
    assign w_alu_en  = w_exec && (w_cls == CLS_ALU);
    assign w_we      = w_exec && ((w_cls == CLS_ALU) || (w_cls == CLS_LDI));
    assign w_wdata   = (w_cls == CLS_ALU) ? alu_out : w_imm;
    assign w_pc_next = (w_cls == CLS_JMP) ? w_imm : r_pc + WORD_SIZE'(1);

    // Operands come straight from the register file during EXECUTE, so the
    // write at the end of that cycle is only seen by later instructions.
    assign alu_opcode = w_alu_en ? CMD_SIZE'(w_cmd) : '0;
    assign alu_r1     = w_alu_en ? w_rdata1 : '0;
    assign alu_r2     = w_alu_en ? w_rdata2 : '0;

    mcpu_regfile #(
        .WORD_SIZE (WORD_SIZE)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (w_we),
        .waddr    (w_rd),
        .wdata    (w_wdata),
        .raddr1   (w_rs1),
        .raddr2   (w_rs2),
        .dbg_sel  (dbg_sel),
        .rdata1   (w_rdata1),
        .rdata2   (w_rdata2),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            ovf_flag   <= 1'b0;
            instr_addr <= '0;
            instr_rd   <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_pc       <= '0;
                        instr_addr <= '0;
                        instr_rd   <= 1'b1;
                        busy       <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_state  <= ST_DECODE;
                    instr_rd <= 1'b0;
                end
                ST_DECODE: begin
                    r_state <= ST_EXECUTE;
                    r_ir    <= instr_data;
                end
                ST_EXECUTE: begin
                    if (w_cls == CLS_HALT) begin
                        r_state <= ST_HALTED;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_pc       <= w_pc_next;
                        instr_addr <= w_pc_next;
                        instr_rd   <= 1'b1;
                        if (w_cls == CLS_ALU) begin
                            ovf_flag <= alu_overflow;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
